// File: rtl/sr_pkg.sv
// ============================================================================
// Module      : sr_pkg
// Description : Shared constants and S/R resolution helper for the clocked
//               SR flag register. Optional macro: SR_JK_TOGGLE_EN (S=R=1
//               toggles the bit instead of using PRIORITY).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sr_pkg;

    // S=R=1 resolution encodings; any other value behaves as hold
    localparam int SR_PRI_HOLD = 0;
    localparam int SR_PRI_SET  = 1;
    localparam int SR_PRI_RST  = 2;

    // Default sizing for the flag register
    localparam int c_DEFAULT_WIDTH = 4;
    localparam int c_DEFAULT_CNT_W = 8;

    // Per-bit action chosen from the S/R request pair
    typedef enum logic [1:0] {
        SR_ACT_HOLD = 2'd0,
        SR_ACT_SET  = 2'd1,
        SR_ACT_CLR  = 2'd2,
        SR_ACT_TGL  = 2'd3
    } sr_action_e;

    // Maps one S/R pair to an action; the S=R=1 case depends on the build
    function automatic sr_action_e sr_resolve(input logic s, input logic r,
                                              input int pri);
        sr_action_e act;
        act = SR_ACT_HOLD;
        case ({s, r})
            2'b10:   act = SR_ACT_SET;
            2'b01:   act = SR_ACT_CLR;
            2'b11: begin
`ifdef SR_JK_TOGGLE_EN
                act = SR_ACT_TGL;
`else
                if (pri == SR_PRI_SET)
                    act = SR_ACT_SET;
                else if (pri == SR_PRI_RST)
                    act = SR_ACT_CLR;
                else
                    act = SR_ACT_HOLD;
`endif
            end
            default: act = SR_ACT_HOLD;
        endcase
        return act;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sr_cell.sv
// ============================================================================
// Module      : sr_cell
// Description : Single clocked SR storage bit with registered rise/fall
//               change-detect pulses. Optional macro: SR_JK_TOGGLE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_cell
    import sr_pkg::*;
#(
    parameter int PRIORITY = SR_PRI_HOLD
) (
    input  logic Clk,
    input  logic Rst,
    input  logic En,
    input  logic S,
    input  logic R,
    output logic Q,
    output logic Rise,
    output logic Fall
);

    sr_action_e w_action;
    logic       w_next;
    logic       r_q;
    logic       r_rise;
    logic       r_fall;

    // Decode the request pair into the bit's candidate next value
    always_comb begin
        w_action = sr_resolve(S, R, PRIORITY);
        w_next   = r_q;
        case (w_action)
            SR_ACT_SET: w_next = 1'b1;
            SR_ACT_CLR: w_next = 1'b0;
            SR_ACT_TGL: w_next = ~r_q;
            default:    w_next = r_q;
        endcase
    end

    // State bit plus pulses that line up with the first cycle of a new value
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_q    <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else if (En) begin
            r_q    <= w_next;
            r_rise <= ~r_q & w_next;
            r_fall <= r_q & ~w_next;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end
    end

    assign Q    = r_q;
    assign Rise = r_rise;
    assign Fall = r_fall;

endmodule

`default_nettype wire

// File: rtl/sr_flag_register.sv
// ============================================================================
// Module      : sr_flag_register
// Description : WIDTH clocked SR flag bits sharing one enable, with per-bit
//               change pulses, a sticky conflict flag and a saturating
//               conflict counter. Optional macro: SR_JK_TOGGLE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_flag_register
    import sr_pkg::*;
#(
    parameter int WIDTH    = c_DEFAULT_WIDTH,
    parameter int PRIORITY = SR_PRI_HOLD,
    parameter int CNT_W    = c_DEFAULT_CNT_W
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    input  logic             ErrClr,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] notQ,
    output logic [WIDTH-1:0] Rise,
    output logic [WIDTH-1:0] Fall,
    output logic             Conflict,
    output logic [CNT_W-1:0] ConflictCnt
);

    logic             w_conflict;
    logic             r_conflict;
    logic [CNT_W-1:0] r_cnt;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            sr_cell #(
                .PRIORITY (PRIORITY)
            ) u_cell (
                .Clk  (Clk),
                .Rst  (Rst),
                .En   (En),
                .S    (S[gi]),
                .R    (R[gi]),
                .Q    (Q[gi]),
                .Rise (Rise[gi]),
                .Fall (Fall[gi])
            );
        end
    endgenerate

    // A conflict cycle is counted once no matter how many bits collide
    assign w_conflict = En & (|(S & R));

    // Sticky flag and saturating counter; a fresh conflict beats ErrClr
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_conflict <= 1'b0;
            r_cnt      <= '0;
        end else if (w_conflict) begin
            r_conflict <= 1'b1;
            if (ErrClr)
                r_cnt <= CNT_W'(1);
            else if (!(&r_cnt))
                r_cnt <= r_cnt + CNT_W'(1);
        end else if (ErrClr) begin
            r_conflict <= 1'b0;
            r_cnt      <= '0;
        end
    end

    assign notQ        = ~Q;
    assign Conflict    = r_conflict;
    assign ConflictCnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_sr_flag_register.sv
// ============================================================================
// Module      : tb_sr_flag_register
// Description : Scoreboard bench for sr_flag_register. Three instances
//               (PRIORITY 0/1/2, WIDTH=4, CNT_W=2) share one stimulus
//               stream; directed vectors carry hand-computed results.
//               Optional macro: SR_JK_TOGGLE_EN selects the toggle sequence.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sr_flag_register;

    localparam int c_NDUT = 3;

    typedef struct packed {
        logic            rst;
        logic            en;
        logic            clr;
        logic [3:0]      s;
        logic [3:0]      r;
        logic [2:0][3:0] q;
        logic [2:0][3:0] rise;
        logic [2:0][3:0] fall;
        logic            conf;
        logic [1:0]      cnt;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] s   = 4'h0;
    logic [3:0] r   = 4'h0;

    logic [3:0] dq    [c_NDUT];
    logic [3:0] dnq   [c_NDUT];
    logic [3:0] drise [c_NDUT];
    logic [3:0] dfall [c_NDUT];
    logic       dconf [c_NDUT];
    logic [1:0] dcnt  [c_NDUT];

    vec_t stim[$];
    vec_t sb[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    genvar gp;
    generate
        for (gp = 0; gp < c_NDUT; gp++) begin : g_dut
            sr_flag_register #(
                .WIDTH    (4),
                .PRIORITY (gp),
                .CNT_W    (2)
            ) u_dut (
                .Clk         (clk),
                .Rst         (rst),
                .En          (en),
                .S           (s),
                .R           (r),
                .ErrClr      (clr),
                .Q           (dq[gp]),
                .notQ        (dnq[gp]),
                .Rise        (drise[gp]),
                .Fall        (dfall[gp]),
                .Conflict    (dconf[gp]),
                .ConflictCnt (dcnt[gp])
            );
        end
    endgenerate

    task automatic add(input logic a_rst, input logic a_en, input logic a_clr,
                       input logic [3:0] a_s, input logic [3:0] a_r,
                       input logic [3:0] q0, input logic [3:0] q1, input logic [3:0] q2,
                       input logic [3:0] ri0, input logic [3:0] ri1, input logic [3:0] ri2,
                       input logic [3:0] f0, input logic [3:0] f1, input logic [3:0] f2,
                       input logic a_conf, input logic [1:0] a_cnt);
        vec_t v;
        v.rst = a_rst; v.en = a_en; v.clr = a_clr; v.s = a_s; v.r = a_r;
        v.q    = {q2, q1, q0};
        v.rise = {ri2, ri1, ri0};
        v.fall = {f2, f1, f0};
        v.conf = a_conf; v.cnt = a_cnt;
        stim.push_back(v);
    endtask

    task automatic chk(input string name, input int p, input int vidx,
                       input logic [3:0] act, input logic [3:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s dut%0d vec%0d: got %b expected %b", name, p, vidx, act, exp);
        end
    endtask

    // Monitor: compare every DUT against the oldest expectation after each edge
    int   mon_idx = 0;
    vec_t e;
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int p = 0; p < c_NDUT; p++) begin
                chk("Q",           p, mon_idx, dq[p],    e.q[p]);
                chk("notQ",        p, mon_idx, dnq[p],   ~e.q[p]);
                chk("Rise",        p, mon_idx, drise[p], e.rise[p]);
                chk("Fall",        p, mon_idx, dfall[p], e.fall[p]);
                chk("Conflict",    p, mon_idx, {3'b000, dconf[p]}, {3'b000, e.conf});
                chk("ConflictCnt", p, mon_idx, {2'b00, dcnt[p]},   {2'b00, e.cnt});
            end
            mon_idx++;
        end
    end

    // Driver: apply one vector per cycle and hand its expectation to the monitor
    initial begin
        vec_t v;
        int   wait_cycles;
        //    rst en clr s       r        Q0       Q1       Q2       Rise0..2                    Fall0..2                    conf cnt
        add(1, 0, 0, 4'h0, 4'h0,   4'h0, 4'h0, 4'h0,   4'h0, 4'h0, 4'h0,   4'h0, 4'h0, 4'h0,   0, 2'd0);
        add(1, 0, 0, 4'hF, 4'h0,   4'h0, 4'h0, 4'h0,   4'h0, 4'h0, 4'h0,   4'h0, 4'h0, 4'h0,   0, 2'd0);
        add(0, 0, 0, 4'hF, 4'h0,   4'h0, 4'h0, 4'h0,   4'h0, 4'h0, 4'h0,   4'h0, 4'h0, 4'h0,   0, 2'd0);
        add(0, 1, 0, 4'h5, 4'h0,   4'h5, 4'h5, 4'h5,   4'h5, 4'h5, 4'h5,   4'h0, 4'h0, 4'h0,   0, 2'd0);
        add(0, 0, 0, 4'h0, 4'h0,   4'h5, 4'h5, 4'h5,   4'h0, 4'h0, 4'h0,   4'h0, 4'h0, 4'h0,   0, 2'd0);
        add(0, 1, 0, 4'h0, 4'h1,   4'h4, 4'h4, 4'h4,   4'h0, 4'h0, 4'h0,   4'h1, 4'h1, 4'h1,   0, 2'd0);
        add(0, 1, 0, 4'h3, 4'h4,   4'h3, 4'h3, 4'h3,   4'h3, 4'h3, 4'h3,   4'h4, 4'h4, 4'h4,   0, 2'd0);
`ifdef SR_JK_TOGGLE_EN
        add(0, 1, 0, 4'hA, 4'h5,   4'hA, 4'hA, 4'hA,   4'h8, 4'h8, 4'h8,   4'h1, 4'h1, 4'h1,   0, 2'd0);
        add(0, 1, 0, 4'hF, 4'hF,   4'h5, 4'h5, 4'h5,   4'h5, 4'h5, 4'h5,   4'hA, 4'hA, 4'hA,   1, 2'd1);
        add(0, 1, 0, 4'hF, 4'hF,   4'hA, 4'hA, 4'hA,   4'hA, 4'hA, 4'hA,   4'h5, 4'h5, 4'h5,   1, 2'd2);
        add(0, 1, 0, 4'hF, 4'h0,   4'hF, 4'hF, 4'hF,   4'h5, 4'h5, 4'h5,   4'h0, 4'h0, 4'h0,   1, 2'd2);
`else
        // priority sweep from Q=0011 with S=R=0101
        add(0, 1, 0, 4'h5, 4'h5,   4'h3, 4'h7, 4'h2,   4'h0, 4'h4, 4'h0,   4'h0, 4'h0, 4'h1,   1, 2'd1);
        // ErrClr alone
        add(0, 0, 1, 4'h0, 4'h0,   4'h3, 4'h7, 4'h2,   4'h0, 4'h0, 4'h0,   4'h0, 4'h0, 4'h0,   0, 2'd0);
        // five conflict cycles on bit 3: counter saturates at 3
        add(0, 1, 0, 4'h8, 4'h8,   4'h3, 4'hF, 4'h2,   4'h0, 4'h8, 4'h0,   4'h0, 4'h0, 4'h0,   1, 2'd1);
        add(0, 1, 0, 4'h8, 4'h8,   4'h3, 4'hF, 4'h2,   4'h0, 4'h0, 4'h0,   4'h0, 4'h0, 4'h0,   1, 2'd2);
        add(0, 1, 0, 4'h8, 4'h8,   4'h3, 4'hF, 4'h2,   4'h0, 4'h0, 4'h0,   4'h0, 4'h0, 4'h0,   1, 2'd3);
        add(0, 1, 0, 4'h8, 4'h8,   4'h3, 4'hF, 4'h2,   4'h0, 4'h0, 4'h0,   4'h0, 4'h0, 4'h0,   1, 2'd3);
        add(0, 1, 0, 4'h8, 4'h8,   4'h3, 4'hF, 4'h2,   4'h0, 4'h0, 4'h0,   4'h0, 4'h0, 4'h0,   1, 2'd3);
        // ErrClr alone, then ErrClr together with a conflict
        add(0, 1, 1, 4'h0, 4'h0,   4'h3, 4'hF, 4'h2,   4'h0, 4'h0, 4'h0,   4'h0, 4'h0, 4'h0,   0, 2'd0);
        add(0, 1, 1, 4'h8, 4'h8,   4'h3, 4'hF, 4'h2,   4'h0, 4'h0, 4'h0,   4'h0, 4'h0, 4'h0,   1, 2'd1);
        // drive all bits to 1
        add(0, 1, 0, 4'hF, 4'h0,   4'hF, 4'hF, 4'hF,   4'hC, 4'h0, 4'hD,   4'h0, 4'h0, 4'h0,   1, 2'd1);
`endif
        // reset with Q=F and competing inputs: no Fall pulse
        add(1, 1, 0, 4'h0, 4'hF,   4'h0, 4'h0, 4'h0,   4'h0, 4'h0, 4'h0,   4'h0, 4'h0, 4'h0,   0, 2'd0);
        // S=R=1 with En low: no update, no conflict
        add(0, 0, 0, 4'hF, 4'hF,   4'h0, 4'h0, 4'h0,   4'h0, 4'h0, 4'h0,   4'h0, 4'h0, 4'h0,   0, 2'd0);
        add(0, 1, 0, 4'h2, 4'h0,   4'h2, 4'h2, 4'h2,   4'h2, 4'h2, 4'h2,   4'h0, 4'h0, 4'h0,   0, 2'd0);

        while (stim.size() > 0) begin
            v = stim.pop_front();
            @(negedge clk);
            rst = v.rst; en = v.en; clr = v.clr; s = v.s; r = v.r;
            sb.push_back(v);
        end
        @(negedge clk);
        rst = 1'b0; en = 1'b0; clr = 1'b0; s = 4'h0; r = 4'h0;
        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 20) begin
            @(negedge clk);
            wait_cycles++;
        end
        if (sb.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
